// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM loader: state encoding, bus widths,
// and the byte-lane mask used when comparing readback data.
package rom_loader_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam logic [MEM_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Expand a 4-bit lane select into a 32-bit bit mask.
  function automatic logic [MEM_DATA_W-1:0] lane_mask(input logic [3:0] sel);
    logic [MEM_DATA_W-1:0] m;
    m = ZERO_WORD;
    for (int n = 0; n < 4; n++) begin
      m[8*n +: 8] = {8{sel[n]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Little-endian byte packer: accumulates bytes into a word, tracking which
// lanes have been filled. Clear has priority over load.
module rom_loader_byte_packer
  import rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  output logic [1:0]            lane_o,
  output logic [MEM_DATA_W-1:0] data_o,
  output logic [3:0]            sel_o
);

  logic [1:0]            lane_q;
  logic [MEM_DATA_W-1:0] data_q;
  logic [3:0]            sel_q;

  // Lane counter and data/select accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= 2'd0;
      data_q <= ZERO_WORD;
      sel_q  <= 4'b0000;
    end else if (clr_i) begin
      lane_q <= 2'd0;
      data_q <= ZERO_WORD;
      sel_q  <= 4'b0000;
    end else if (load_i) begin
      data_q[{lane_q, 3'b000} +: 8] <= byte_i;
      sel_q[lane_q]                 <= 1'b1;
      lane_q                        <= lane_q + 2'd1;
    end
  end

  assign lane_o = lane_q;
  assign data_o = data_q;
  assign sel_o  = sel_q;

endmodule

// File: rtl/rom_loader.sv
// ROM loader: takes a byte stream, packs it into words, writes each word to
// the ROM and optionally reads it back to check it. Keeps a running checksum
// of accepted bytes and a sticky mismatch flag.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter bit VERIFY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [MEM_ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [MEM_ADDR_W-1:0] addr_o,
  output logic [MEM_DATA_W-1:0] data_o,
  output logic [3:0]            sel_o,
  input  logic [MEM_DATA_W-1:0] rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           checksum_o
);

  state_e                state_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]      remaining_q;
  logic                  err_q;
  logic [31:0]           checksum_q;

  logic [1:0]            pk_lane;
  logic [MEM_DATA_W-1:0] pk_data;
  logic [3:0]            pk_sel;
  logic                  pk_clr;
  logic                  pk_load;

  logic accept;
  logic advance;
  logic verify_fail;

  // Handshake and word-step decode; the packer is frozen on abort.
  assign accept      = (state_q == S_FILL) & byte_valid_i;
  assign advance     = (state_q == S_VERIFY) | ((state_q == S_WRITE) & (VERIFY == 1'b0));
  assign verify_fail = |((rdata_i ^ pk_data) & lane_mask(pk_sel));
  assign pk_load     = accept & ~abort_i;
  assign pk_clr      = ~abort_i & (((state_q == S_IDLE) & start_i) |
                                   (advance & (remaining_q != '0)));

  rom_loader_byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pk_clr),
    .load_i (pk_load),
    .byte_i (byte_i),
    .lane_o (pk_lane),
    .data_o (pk_data),
    .sel_o  (pk_sel)
  );

  // Sequencer: state, word address, byte budget, checksum and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q      <= base_addr_i & ~32'h3;
            remaining_q <= len_i;
            err_q       <= 1'b0;
            checksum_q  <= '0;
            state_q     <= (len_i == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            remaining_q <= remaining_q - LEN_W'(1);
            checksum_q  <= checksum_q + {24'd0, byte_i};
            if ((pk_lane == 2'd3) || (remaining_q == LEN_W'(1))) begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (VERIFY) begin
            state_q <= S_VERIFY;
          end else if (remaining_q == '0) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + 32'd4;
            state_q <= S_FILL;
          end
        end
        S_VERIFY: begin
          if (verify_fail) begin
            err_q <= 1'b1;
          end
          if (remaining_q == '0) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + 32'd4;
            state_q <= S_FILL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = (state_q == S_FILL);
  assign we_o         = (state_q == S_WRITE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign addr_o       = addr_q;
  assign data_o       = pk_data;
  assign sel_o        = pk_sel;
  assign err_o        = err_q;
  assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a small byte-lane ROM model.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i, byte_ready_o;
  logic        we_o;
  logic [31:0] addr_o, data_o, rdata_i;
  logic [3:0]  sel_o;
  logic        busy_o, done_o, err_o;
  logic [31:0] checksum_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_loader #(.LEN_W(16), .VERIFY(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .sel_o        (sel_o),
    .rdata_i      (rdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .checksum_o   (checksum_o)
  );

  // ROM model with optional corruption of lane 2 on one address.
  logic [31:0] mem [0:255];
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  always_comb begin
    rdata_i = mem[addr_o[9:2]];
    if (corrupt_en && addr_o == corrupt_addr) rdata_i = rdata_i ^ 32'h00FF0000;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    end else if (we_o) begin
      for (int n = 0; n < 4; n++)
        if (sel_o[n]) mem[addr_o[9:2]][8*n +: 8] <= data_o[8*n +: 8];
    end
  end

  // Bus monitor: logs writes, counts done pulses and ready cycles.
  int          wr_n = 0, done_n = 0, ready_n = 0;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic [3:0]  log_sel  [0:63];
  logic        log_err  [0:63];

  always @(negedge clk) begin
    if (we_o && wr_n < 64) begin
      log_addr[wr_n] = addr_o;
      log_data[wr_n] = data_o;
      log_sel[wr_n]  = sel_o;
      log_err[wr_n]  = err_o;
      wr_n = wr_n + 1;
    end
    if (done_o) done_n = done_n + 1;
    if (byte_ready_o) ready_n = ready_n + 1;
  end

  task automatic do_start(input logic [31:0] base, input logic [15:0] len);
    base_addr_i = base;
    len_i       = len;
    start_i     = 1'b1;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  // Feed n bytes first, first+step, ...; optional idle gap before each byte and
  // an extra start pulse driven alongside byte number mid_start.
  task automatic feed(input logic [7:0] first, input logic [7:0] step, input int n,
                      input bit gap, input int mid_start);
    bit hs;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        byte_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      byte_i       = first + 8'(i) * step;
      byte_valid_i = 1'b1;
      if (i == mid_start) begin
        start_i     = 1'b1;
        base_addr_i = 32'h900;
        len_i       = 16'd2;
      end
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        hs = byte_ready_o;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL feed_handshake byte %0d: ready never seen, required within 50 cycles", i);
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = max;
    for (int c = 0; c < max && !seen; c++) begin
      @(negedge clk);
      if (done_o) begin
        seen   = 1'b1;
        cycles = c;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done_o not seen within %0d cycles", max);
    end
  endtask

  task automatic check_two_words(input int i0, input string tag);
    checks++;
    if (wr_n - i0 !== 2) begin errors++; $display("FAIL %s write_count got %0d want 2", tag, wr_n - i0); end
    else begin
      checks++;
      if (log_addr[i0] !== 32'h100) begin errors++; $display("FAIL %s w0_addr got %h want 00000100", tag, log_addr[i0]); end
      checks++;
      if (log_data[i0] !== 32'h04030201) begin errors++; $display("FAIL %s w0_data got %h want 04030201", tag, log_data[i0]); end
      checks++;
      if (log_sel[i0] !== 4'hF) begin errors++; $display("FAIL %s w0_sel got %b want 1111", tag, log_sel[i0]); end
      checks++;
      if (log_addr[i0+1] !== 32'h104) begin errors++; $display("FAIL %s w1_addr got %h want 00000104", tag, log_addr[i0+1]); end
      checks++;
      if (log_data[i0+1] !== 32'h08070605) begin errors++; $display("FAIL %s w1_data got %h want 08070605", tag, log_data[i0+1]); end
      checks++;
      if (log_sel[i0+1] !== 4'hF) begin errors++; $display("FAIL %s w1_sel got %b want 1111", tag, log_sel[i0+1]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; base_addr_i = '0; len_i = '0;
    byte_i = '0; byte_valid_i = 1'b0;
    #3;
    checks++;
    if ({busy_o, byte_ready_o, we_o, done_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {busy_o, byte_ready_o, we_o, done_o, err_o});
    end
    checks++;
    if ({addr_o, data_o, checksum_o, sel_o} !== 100'b0) begin
      errors++; $display("FAIL reset_buses addr %h data %h sum %h sel %b want all zero", addr_o, data_o, checksum_o, sel_o);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    int i0, d0, cyc;
    i0 = wr_n; d0 = done_n;
    do_start(32'h100, 16'd8);
    feed(8'h01, 8'h01, 8, 1'b0, -1);
    wait_done(20, cyc);
    check_two_words(i0, "full");
    checks++;
    if (checksum_o !== 32'h24) begin errors++; $display("FAIL full_checksum got %h want 00000024", checksum_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", err_o); end
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_n - d0); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL full_idle busy got %b want 0", busy_o); end
  endtask

  task automatic test_partial();
    int i0, cyc;
    i0 = wr_n;
    do_start(32'h203, 16'd3);
    feed(8'hAA, 8'h11, 3, 1'b0, -1);
    wait_done(20, cyc);
    checks++;
    if (wr_n - i0 !== 1) begin errors++; $display("FAIL partial_write_count got %0d want 1", wr_n - i0); end
    else begin
      checks++;
      if (log_addr[i0] !== 32'h200) begin errors++; $display("FAIL partial_addr got %h want 00000200", log_addr[i0]); end
      checks++;
      if (log_data[i0] !== 32'h00CCBBAA) begin errors++; $display("FAIL partial_data got %h want 00ccbbaa", log_data[i0]); end
      checks++;
      if (log_sel[i0] !== 4'b0111) begin errors++; $display("FAIL partial_sel got %b want 0111", log_sel[i0]); end
    end
    checks++;
    if (checksum_o !== 32'h231) begin errors++; $display("FAIL partial_checksum got %h want 00000231", checksum_o); end
  endtask

  task automatic test_verify_error();
    int i0, d0, cyc;
    i0 = wr_n; d0 = done_n;
    corrupt_en = 1'b1; corrupt_addr = 32'h104;
    do_start(32'h100, 16'd8);
    feed(8'h11, 8'h11, 8, 1'b0, -1);
    wait_done(20, cyc);
    checks++;
    if (wr_n - i0 !== 2) begin errors++; $display("FAIL verr_write_count got %0d want 2", wr_n - i0); end
    else begin
      checks++;
      if (log_err[i0+1] !== 1'b0) begin errors++; $display("FAIL verr_err_after_word0 got %b want 0", log_err[i0+1]); end
    end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL verr_err_after_word1 got %b want 1", err_o); end
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL verr_done_count got %0d want 1", done_n - d0); end
    checks++;
    if (checksum_o !== 32'h264) begin errors++; $display("FAIL verr_checksum got %h want 00000264", checksum_o); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL verr_sticky got %b want 1", err_o); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_zero_len();
    int i0, d0, r0, cyc;
    i0 = wr_n; d0 = done_n; r0 = ready_n;
    do_start(32'h400, 16'd0);
    wait_done(10, cyc);
    checks++;
    if (cyc !== 0) begin errors++; $display("FAIL zero_done_latency got %0d want 0 extra cycles", cyc); end
    checks++;
    if (wr_n - i0 !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_n - i0); end
    checks++;
    if (ready_n - r0 !== 0) begin errors++; $display("FAIL zero_ready_cycles got %0d want 0", ready_n - r0); end
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_n - d0); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL zero_err_cleared got %b want 0", err_o); end
    checks++;
    if (checksum_o !== 32'h0) begin errors++; $display("FAIL zero_checksum got %h want 00000000", checksum_o); end
  endtask

  task automatic test_back_to_back();
    int i0, d0, cyc;
    i0 = wr_n; d0 = done_n;
    do_start(32'h100, 16'd8);
    feed(8'h01, 8'h01, 8, 1'b1, 3);
    wait_done(30, cyc);
    check_two_words(i0, "gapped");
    checks++;
    if (done_n - d0 !== 1) begin errors++; $display("FAIL gapped_done_count got %0d want 1", done_n - d0); end
    checks++;
    if (checksum_o !== 32'h24) begin errors++; $display("FAIL gapped_checksum got %h want 00000024", checksum_o); end
  endtask

  task automatic test_abort_and_reset();
    int i0, d0;
    i0 = wr_n; d0 = done_n;
    do_start(32'h100, 16'd8);
    feed(8'h01, 8'h01, 6, 1'b0, -1);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b want 0", busy_o); end
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (wr_n - i0 !== 1) begin errors++; $display("FAIL abort_write_count got %0d want 1", wr_n - i0); end
    checks++;
    if (done_n - d0 !== 0) begin errors++; $display("FAIL abort_done_count got %0d want 0", done_n - d0); end

    i0 = wr_n;
    do_start(32'h300, 16'd8);
    feed(8'h01, 8'h01, 2, 1'b0, -1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, byte_ready_o, we_o, done_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b want 00000", {busy_o, byte_ready_o, we_o, done_o, err_o});
    end
    checks++;
    if ({addr_o, data_o, checksum_o, sel_o} !== 100'b0) begin
      errors++; $display("FAIL rst_mid_buses addr %h data %h sum %h sel %b want all zero", addr_o, data_o, checksum_o, sel_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_n - i0 !== 0) begin errors++; $display("FAIL rst_mid_writes got %0d want 0", wr_n - i0); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_verify_error();
    test_zero_len();
    test_back_to_back();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
